ecore_rf_seq: RTL

Sequencer that shares the core's single-port synchronous register file between operand reads and writeback. Accepts operand read requests (rs1, optional rs2) and write requests, and serialises them onto the one register-file port. Drives the port's address, write-enable and write-data, and captures read data. Sits between ecore's decode/execute state machine and the 15-entry RV32E register file.

---
 rtl/ecore_pkg.sv | 35 +++
 rtl/ecore_rf_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ecore_pkg.sv
// Shared types and constants for the ecore register-file sequencer.
// Holds the sequencer state encoding and register-number helpers.
package ecore_pkg;

  localparam int XLEN        = 32;
  localparam int RF_AW       = 4;
  localparam int REG_NUM_W   = 5;
  localparam int REG_ZERO    = 0;
  localparam int RV32E_NREGS = 16;

  typedef enum logic [2:0] {
    IDLE,
    A1,
    A2,
    C1,
    C2,
    RSP,
    WR
  } state_t;

  // Register number exists in RV32E (x0..x15).
  function automatic logic reg_ok(
    input logic [REG_NUM_W-1:0] r
  );
    return r < REG_NUM_W'(RV32E_NREGS);
  endfunction

  // Register needs a real port access: legal and not x0.
  function automatic logic reg_real(
    input logic [REG_NUM_W-1:0] r
  );
    return reg_ok(r) && (r != REG_NUM_W'(REG_ZERO));
  endfunction

endpackage

// File: rtl/ecore_rf_seq.sv
// Serialises operand reads and writeback onto the single RF port.
// Ports: rd req/rsp handshake, wr handshake, RF addr/we/wdata/rdata.
// Option ECORE_RF_X0_SKIP_EN: x0/illegal/unrequested reads skip
// the port cycle, shortening read latency.
module ecore_rf_seq #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rd_valid,
  output logic             o_rd_ready,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic             i_need_rs2,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [XLEN-1:0]  o_rs1_data,
  output logic [XLEN-1:0]  o_rs2_data,
  output logic             o_rsp_err,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [4:0]       i_wr_addr,
  input  logic [XLEN-1:0]  i_wr_data,
  output logic             o_wr_err,
  output logic [RF_AW-1:0] o_rf_addr,
  output logic             o_rf_we,
  output logic [XLEN-1:0]  o_rf_wdata,
  input  logic [XLEN-1:0]  i_rf_rdata
);
  import ecore_pkg::*;

  state_t state_q, state_d;

  logic [RF_AW-1:0]     rs1_q, rs2_q;
  logic [REG_NUM_W-1:0] wa_q;
  logic [XLEN-1:0]      wd_q, d1_q, d2_q;
  // two_q: both operands use the port (A1->A2->C2)
  // f2_q: single port read is rs2, not rs1
  // v1_q/v2_q: captured value is real (else stays 0)
  logic two_q, f2_q, v1_q, v2_q, err_q;

  logic real1, real2, err_n;
  logic two_n, f2_n, none_n;

  assign real1 = reg_real(i_rs1);
  assign real2 = i_need_rs2 & reg_real(i_rs2);
  assign err_n = !reg_ok(i_rs1)
               | (i_need_rs2 & !reg_ok(i_rs2));

`ifdef ECORE_RF_X0_SKIP_EN
  assign two_n  = real1 & real2;
  assign f2_n   = !real1 & real2;
  assign none_n = !real1 & !real2;
`else
  assign two_n  = i_need_rs2;
  assign f2_n   = 1'b0;
  assign none_n = 1'b0;
`endif

  assign o_rs1_data = d1_q;
  assign o_rs2_data = d2_q;
  assign o_rsp_err  = (state_q == RSP) & err_q;

  always_comb begin
    state_d     = state_q;
    o_rd_ready  = 1'b0;
    o_wr_ready  = 1'b0;
    o_rsp_valid = 1'b0;
    o_wr_err    = 1'b0;
    o_rf_addr   = '0;
    o_rf_we     = 1'b0;
    o_rf_wdata  = '0;
    unique case (state_q)
      IDLE: begin
        // Readies are held low while reset is asserted.
        o_wr_ready = i_rst_n;
        o_rd_ready = i_rst_n & !i_wr_valid;
        if (i_wr_valid)
          state_d = WR;
        else if (i_rd_valid)
          state_d = none_n ? RSP : A1;
      end
      WR: begin
        if (!reg_ok(wa_q)) begin
          o_wr_err = 1'b1;
        end else if (reg_real(wa_q)) begin
          o_rf_we    = 1'b1;
          o_rf_addr  = wa_q[RF_AW-1:0];
          o_rf_wdata = wd_q;
        end
        state_d = IDLE;
      end
      A1: begin
        o_rf_addr = f2_q ? rs2_q : rs1_q;
        state_d   = two_q ? A2 : C1;
      end
      A2: begin
        o_rf_addr = rs2_q;
        state_d   = C2;
      end
      C1: state_d = RSP;
      C2: state_d = RSP;
      RSP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      two_q   <= 1'b0;
      f2_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (i_wr_valid) begin
            wa_q <= i_wr_addr;
            wd_q <= i_wr_data;
          end else if (i_rd_valid) begin
            rs1_q <= i_rs1[RF_AW-1:0];
            rs2_q <= i_rs2[RF_AW-1:0];
            two_q <= two_n;
            f2_q  <= f2_n;
            v1_q  <= real1;
            v2_q  <= real2;
            err_q <= err_n;
            d1_q  <= '0;
            d2_q  <= '0;
          end
        end
        A2: if (v1_q) d1_q <= i_rf_rdata;
        C1: begin
          if (f2_q) begin
            if (v2_q) d2_q <= i_rf_rdata;
          end else if (v1_q) begin
            d1_q <= i_rf_rdata;
          end
        end
        C2: if (v2_q) d2_q <= i_rf_rdata;
        default: ;
      endcase
    end
  end

endmodule
